exec_writeback_stage: RTL



---
 rtl/exec_writeback_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/exec_writeback_stage.sv
// rtl/exec_writeback_stage.sv - ALU writeback stage: condition check, flag commit, 2-entry result queue
// Optional feature macro: COND_EXEC_EN (condition-code evaluation and annul counter).
// exec_wb_queue ports: flush_i empties, push_i/push_data_i enqueue, pop_i dequeues,
//   count_o occupancy 0..2, head_o oldest entry.
// exec_writeback_stage ports: clk_i, rst_n_i (async active-low); in_valid_i/in_ready_o with
//   result_i, n_i/z_i/c_i/v_i, rd_i, reg_we_i, flag_we_i, cond_i from the ALU; flush_i discard;
//   out_valid_o/out_ready_i with wb_data_o, wb_rd_o, wb_we_o to the register file;
//   flags_o architectural {N,Z,C,V}; annul_cnt_o saturating count of condition-failed accepts.

module exec_wb_queue #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);
    logic [1:0]   count_q, count_d;
    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         do_push, do_pop;

    // Guards keep the queue self-consistent even if the caller misbehaves.
    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i  && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (do_push && do_pop) begin
            // Only reachable with one entry held: the new entry becomes the head.
            mem0_d = push_data_i;
        end else if (do_push) begin
            if (count_q == 2'd0) begin
                mem0_d = push_data_i;
            end else begin
                mem1_d = push_data_i;
            end
            count_d = count_q + 2'd1;
        end else if (do_pop) begin
            mem0_d  = mem1_q;
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 2'd0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            count_q <= count_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem0_q;
endmodule

module exec_writeback_stage #(
    parameter int N  = 4,
    parameter int RW = 4,
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [N-1:0]  result_i,
    input  logic          n_i,
    input  logic          z_i,
    input  logic          c_i,
    input  logic          v_i,
    input  logic [RW-1:0] rd_i,
    input  logic          reg_we_i,
    input  logic          flag_we_i,
    input  logic [3:0]    cond_i,
    input  logic          flush_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [N-1:0]  wb_data_o,
    output logic [RW-1:0] wb_rd_o,
    output logic          wb_we_o,
    output logic [3:0]    flags_o,
    output logic [CW-1:0] annul_cnt_o
);
    localparam int EW = N + RW + 1;

    logic [3:0]    flags_q, flags_d;
    logic          pass;
    logic          accept;
    logic          pop;
    logic [1:0]    count;
    logic [EW-1:0] head;

    // Both ready and valid come from the registered count only.
    assign in_ready_o  = (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i;

`ifdef COND_EXEC_EN
    logic          f_n, f_z, f_c, f_v;
    logic [CW-1:0] annul_q, annul_d;

    assign {f_n, f_z, f_c, f_v} = flags_q;

    always_comb begin
        pass = 1'b0;
        case (cond_i)
            4'd0:    pass = f_z;
            4'd1:    pass = !f_z;
            4'd2:    pass = f_c;
            4'd3:    pass = !f_c;
            4'd4:    pass = f_n;
            4'd5:    pass = !f_n;
            4'd6:    pass = f_v;
            4'd7:    pass = !f_v;
            4'd8:    pass = f_c && !f_z;
            4'd9:    pass = !f_c || f_z;
            4'd10:   pass = (f_n == f_v);
            4'd11:   pass = (f_n != f_v);
            4'd12:   pass = !f_z && (f_n == f_v);
            4'd13:   pass = f_z || (f_n != f_v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_comb begin
        annul_d = annul_q;
        if (accept && !pass && (annul_q != {CW{1'b1}})) begin
            annul_d = annul_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            annul_q <= '0;
        end else begin
            annul_q <= annul_d;
        end
    end

    assign annul_cnt_o = annul_q;
`else
    logic unused_cond;

    assign pass        = 1'b1;
    assign annul_cnt_o = '0;
    assign unused_cond = ^cond_i;
`endif

    always_comb begin
        flags_d = flags_q;
        if (accept && flag_we_i && pass) begin
            flags_d = {n_i, z_i, c_i, v_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

    // Failed instructions are still queued (with we cleared) to keep ordering.
    exec_wb_queue #(.W(EW)) u_queue (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (flush_i),
        .push_i      (accept),
        .push_data_i ({result_i, rd_i, reg_we_i && pass}),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign wb_data_o = out_valid_o ? head[EW-1 -: N] : '0;
    assign wb_rd_o   = out_valid_o ? head[RW:1]      : '0;
    assign wb_we_o   = out_valid_o && head[0];
endmodule
